alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/AND/OR and an N-cycle shift-add
// signed fixed-point multiply with saturation.
module alu_seq #(
   parameter int N    = 8,
   parameter int FRAC = N - 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   func,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result,
   output logic         busy,
   output logic         done,
   output logic         zero,
   output logic         ovf
);

   typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

   state_t         state, state_next;
   logic [2*N-1:0] mcand, acc, addend, acc_sum, shifted;
   logic [N-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic           accept, mul_start, mul_last;
   logic [N-1:0]   alu_res, mul_res;
   logic           alu_ovf, mul_ovf, in_range;

   // Start is only looked at while idle; a start during a multiply is dropped.
   assign accept    = (state == IDLE) && start;
   assign mul_start = accept && (func == 3'b100);
   assign mul_last  = (state == MUL_RUN) && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mul_start) state_next = MUL_RUN;
         MUL_RUN: if (mul_last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == MUL_RUN);
   end

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (func)
         3'b000: begin
            alu_res = a + b;
            alu_ovf = (a[N-1] == b[N-1]) && (alu_res[N-1] != a[N-1]);
         end
         3'b001: begin
            alu_res = a - b;
            alu_ovf = (a[N-1] != b[N-1]) && (alu_res[N-1] != a[N-1]);
         end
         3'b010:  alu_res = a & b;
         3'b011:  alu_res = a | b;
         default: alu_res = '0;
      endcase
   end

   // The top multiplier bit carries negative weight, so the last step subtracts.
   always_comb begin
      addend   = '0;
      if (mplier[0]) addend = mul_last ? (~mcand + 1'b1) : mcand;
      acc_sum  = acc + addend;
      shifted  = $signed(acc_sum) >>> FRAC;
      in_range = (&shifted[2*N-1:N-1]) || (~|shifted[2*N-1:N-1]);
      mul_res  = in_range ? shifted[N-1:0] : (shifted[2*N-1] ? SAT_NEG : SAT_POS);
      mul_ovf  = ~in_range;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         zero   <= 1'b1;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (mul_start) begin
            mcand  <= {{N{a[N-1]}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
         end else if (accept) begin
            result <= alu_res;
            zero   <= (alu_res == '0);
            ovf    <= alu_ovf;
            done   <= 1'b1;
         end else if (state == MUL_RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               cnt    <= '0;
               result <= mul_res;
               zero   <= (mul_res == '0);
               ovf    <= mul_ovf;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors, randomized operations against an
// integer-arithmetic reference, abort-by-reset and back-to-back starts.
module tb_alu_seq;

   localparam int N    = 8;
   localparam int FRAC = 7;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   func = 3'b000;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [N-1:0] result;
   logic         busy, done, zero, ovf;

   int checks = 0;
   int failures = 0;

   alu_seq #(.N(N), .FRAC(FRAC)) dut (
      .clk(clk), .reset(reset), .start(start), .func(func), .a(a), .b(b),
      .result(result), .busy(busy), .done(done), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference: exact integer arithmetic, then wrap or saturate to N bits.
   function automatic void model(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                                 output logic [N-1:0] r, output logic o);
      longint sa, sb, v, lo, hi;
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      lo = -(longint'(1) <<< (N - 1));
      hi = (longint'(1) <<< (N - 1)) - 1;
      r = '0;
      o = 1'b0;
      case (f)
         3'd0: begin v = sa + sb; o = (v < lo) || (v > hi); r = v[N-1:0]; end
         3'd1: begin v = sa - sb; o = (v < lo) || (v > hi); r = v[N-1:0]; end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: begin
            v = (sa * sb) >>> FRAC;
            if (v > hi)      begin r = hi[N-1:0]; o = 1'b1; end
            else if (v < lo) begin r = lo[N-1:0]; o = 1'b1; end
            else             r = v[N-1:0];
         end
         default: r = '0;
      endcase
   endfunction

   // Issues one operation, scrambles inputs after the sampling edge, and
   // returns in the cycle where done is seen (or after a cycle budget).
   task automatic run_op(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                         output int busy_cycles, output logic done_ok, output logic [N-1:0] r,
                         output logic z, output logic o);
      @(negedge clk);
      start = 1'b1; func = f; a = x; b = y;
      @(negedge clk);
      start = 1'b0; func = 3'($urandom); a = N'($urandom); b = N'($urandom);
      busy_cycles = 0;
      for (int i = 0; i < 4 * N; i++) begin
         if (done) break;
         if (busy) busy_cycles++;
         @(negedge clk);
      end
      done_ok = done && !busy;
      r = result; z = zero; o = ovf;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (result !== '0 || zero !== 1'b1 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: result=%h zero=%b ovf=%b busy=%b done=%b, want 00 1 0 0 0",
                  result, zero, ovf, busy, done);
      end
      // First start is honoured at the first edge with reset low.
      reset = 1'b0; start = 1'b1; func = 3'd0; a = 8'h11; b = 8'h22;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || result !== 8'h33) begin
         failures++;
         $display("FAIL first_start: done=%b result=%h, want 1 33", done, result);
      end
   endtask

   task automatic test_directed;
      int bc; logic dk; logic [N-1:0] r; logic z, o;
      run_op(3'd0, 8'h03, 8'h14, bc, dk, r, z, o);
      checks++;
      if (bc !== 0 || dk !== 1'b1 || r !== 8'h17 || z !== 1'b0 || o !== 1'b0) begin
         failures++;
         $display("FAIL add_03_14: busy_cyc=%0d done=%b r=%h z=%b o=%b, want 0 1 17 0 0", bc, dk, r, z, o);
      end
      run_op(3'd4, 8'h60, 8'h05, bc, dk, r, z, o);
      checks++;
      if (bc !== N || dk !== 1'b1 || r !== 8'h03 || o !== 1'b0) begin
         failures++;
         $display("FAIL mul_60_05: busy_cyc=%0d done=%b r=%h o=%b, want 8 1 03 0", bc, dk, r, o);
      end
      run_op(3'd4, 8'h80, 8'h80, bc, dk, r, z, o);
      checks++;
      if (dk !== 1'b1 || r !== 8'h7F || o !== 1'b1) begin
         failures++;
         $display("FAIL mul_80_80: done=%b r=%h o=%b, want 1 7f 1", dk, r, o);
      end
      run_op(3'd4, 8'hC0, 8'h03, bc, dk, r, z, o);
      checks++;
      if (dk !== 1'b1 || r !== 8'hFE || o !== 1'b0) begin
         failures++;
         $display("FAIL mul_c0_03: done=%b r=%h o=%b, want 1 fe 0", dk, r, o);
      end
      run_op(3'd1, 8'h80, 8'h01, bc, dk, r, z, o);
      checks++;
      if (dk !== 1'b1 || r !== 8'h7F || o !== 1'b1) begin
         failures++;
         $display("FAIL sub_80_01: done=%b r=%h o=%b, want 1 7f 1", dk, r, o);
      end
      run_op(3'd1, 8'h05, 8'h05, bc, dk, r, z, o);
      checks++;
      if (dk !== 1'b1 || r !== 8'h00 || z !== 1'b1 || o !== 1'b0) begin
         failures++;
         $display("FAIL sub_05_05: done=%b r=%h z=%b o=%b, want 1 00 1 0", dk, r, z, o);
      end
      run_op(3'd6, 8'hFF, 8'h01, bc, dk, r, z, o);
      checks++;
      if (bc !== 0 || dk !== 1'b1 || r !== 8'h00 || z !== 1'b1 || o !== 1'b0) begin
         failures++;
         $display("FAIL reserved: busy_cyc=%0d done=%b r=%h z=%b o=%b, want 0 1 00 1 0", bc, dk, r, z, o);
      end
      // done lasts a single cycle
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_width: done=%b one cycle later, want 0", done);
      end
   endtask

   task automatic test_random;
      int bc; logic dk; logic [N-1:0] r, er; logic z, o, eo;
      logic [2:0] f; logic [N-1:0] x, y;
      for (int k = 0; k < 80; k++) begin
         f = 3'($urandom_range(0, 7));
         if (k % 3 == 0) f = 3'd4;
         x = N'($urandom);
         y = N'($urandom);
         model(f, x, y, er, eo);
         run_op(f, x, y, bc, dk, r, z, o);
         checks++;
         if (dk !== 1'b1 || r !== er || o !== eo || z !== (er == '0) || bc !== ((f == 3'd4) ? N : 0)) begin
            failures++;
            $display("FAIL random f=%0d a=%h b=%h: done=%b r=%h o=%b z=%b busy_cyc=%0d, want 1 %h %b %b %0d",
                     f, x, y, dk, r, o, z, bc, er, eo, (er == '0), (f == 3'd4) ? N : 0);
         end
      end
   endtask

   task automatic test_hold;
      logic [N-1:0] r0; logic z0, o0; int bad;
      r0 = result; z0 = zero; o0 = ovf; bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a = N'($urandom); b = N'($urandom); func = 3'($urandom);
         if (result !== r0 || zero !== z0 || ovf !== o0 || done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold: %0d cycles changed, want 0 (result=%h held=%h)", bad, result, r0);
      end
   endtask

   task automatic test_ignore_and_abort;
      int dones; logic [N-1:0] er; logic eo;
      model(3'd4, 8'h55, 8'h33, er, eo);
      @(negedge clk);
      start = 1'b1; func = 3'd4; a = 8'h55; b = 8'h33;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      // cycle 3: an ADD request arrives mid-multiply
      repeat (2) begin @(negedge clk); if (done) dones++; end
      start = 1'b1; func = 3'd0; a = 8'h01; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      if (done) dones++;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL ignore_start: busy=%b after mid-run start, want 1", busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      if (done) dones++;
      checks++;
      if (result !== '0 || zero !== 1'b1 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset: result=%h zero=%b ovf=%b busy=%b done=%b, want 00 1 0 0 0",
                  result, zero, ovf, busy, done);
      end
      repeat (N + 3) begin @(negedge clk); if (done || busy) dones++; end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL abort_no_done: %0d done/busy cycles seen, want 0", dones);
      end
   endtask

   task automatic test_back_to_back;
      int bc; logic dk; logic [N-1:0] r; logic z, o;
      run_op(3'd4, 8'h40, 8'h06, bc, dk, r, z, o);
      checks++;
      if (dk !== 1'b1 || r !== 8'h03 || o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_mul: done=%b r=%h o=%b, want 1 03 0", dk, r, o);
      end
      // still inside the done cycle: start the OR now
      start = 1'b1; func = 3'd3; a = 8'hF0; b = 8'h0F;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== 8'hFF || ovf !== 1'b0 || zero !== 1'b0) begin
         failures++;
         $display("FAIL b2b_or: done=%b busy=%b r=%h o=%b z=%b, want 1 0 ff 0 0",
                  done, busy, result, ovf, zero);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_ignore_and_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
